load_store_unit: RTL

- Memory-stage access controller between the EX/MEM pipeline register and the word-wide, word-addressed data memory.
- Memory has a 1-cycle registered read and accesses only on edges where memRead is low; writes echo the written word on readDataMem.
- Adds byte/halfword loads with sign or zero extension, sub-word stores by read-modify-write, misalignment detection, and a stall to the pipeline.

---
 rtl/mips_mem_pkg.sv | 42 ++++
 rtl/load_store_unit_subword_align.sv | 55 +++++
 rtl/load_store_unit.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/mips_mem_pkg.sv
// Shared encodings, FSM state type and lane helpers for the MIPS memory-stage load/store unit.
package mips_mem_pkg;

  localparam logic [3:0] OP_LB  = 4'b0000;
  localparam logic [3:0] OP_LH  = 4'b0001;
  localparam logic [3:0] OP_LW  = 4'b0010;
  localparam logic [3:0] OP_LBU = 4'b0100;
  localparam logic [3:0] OP_LHU = 4'b0101;
  localparam logic [3:0] OP_SB  = 4'b1000;
  localparam logic [3:0] OP_SH  = 4'b1001;
  localparam logic [3:0] OP_SW  = 4'b1010;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // Big-endian puts byte offset 0 in the most significant lane, so the offset is inverted.
  localparam logic [1:0] LANE_XOR_BE = 2'b11;
  localparam logic [1:0] LANE_XOR_LE = 2'b00;

  typedef enum logic [1:0] {
    IDLE,
    LD_EXT,
    ST_MERGE
  } lsu_state_e;

  function automatic logic op_is_valid(input logic [3:0] op);
    case (op)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    return ((size == SIZE_HALF) && offset[0]) || ((size == SIZE_WORD) && (offset != 2'b00));
  endfunction

  function automatic logic [1:0] lane_of(input logic [1:0] offset, input bit big_endian);
    return offset ^ (big_endian ? LANE_XOR_BE : LANE_XOR_LE);
  endfunction

endpackage

// File: rtl/load_store_unit_subword_align.sv
// Combinational byte/halfword lane logic: load extract with sign/zero extension, and
// store merge of a sub-word into an existing memory word.
module subword_align
  import mips_mem_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic [31:0] word_in,
  input  logic [15:0] new_data,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] load_result,
  output logic [31:0] store_word
);

  logic [1:0]  lane;
  logic [4:0]  shift;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] lane_mask;
  logic [31:0] lane_data;

  always_comb begin
    lane     = lane_of(offset, BIG_ENDIAN);
    shift    = {lane, 3'b000};
    sel_half = lane[1] ? word_in[31:16] : word_in[15:0];
    case (lane)
      2'd0:    sel_byte = word_in[7:0];
      2'd1:    sel_byte = word_in[15:8];
      2'd2:    sel_byte = word_in[23:16];
      default: sel_byte = word_in[31:24];
    endcase

    load_result = word_in;
    lane_mask   = 32'h0000_0000;
    lane_data   = 32'h0000_0000;
    case (size)
      SIZE_BYTE: begin
        load_result = {{24{sel_byte[7] & ~is_unsigned}}, sel_byte};
        lane_mask   = 32'h0000_00FF << shift;
        lane_data   = {24'h00_0000, new_data[7:0]} << shift;
      end
      SIZE_HALF: begin
        load_result = {{16{sel_half[15] & ~is_unsigned}}, sel_half};
        lane_mask   = lane[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
        lane_data   = lane[1] ? {new_data, 16'h0000} : {16'h0000, new_data};
      end
      default: ;
    endcase

    store_word = (word_in & ~lane_mask) | lane_data;
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store controller: sub-word loads with extension, read-modify-write
// sub-word stores, misalignment detection and pipeline stall generation.
module load_store_unit
  import mips_mem_pkg::*;
#(
  parameter int DATA_BITS  = 32,
  parameter int ADDR_BITS  = 32,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req,
  input  logic [3:0]           memOp,
  input  logic [ADDR_BITS-1:0] byteAddr,
  input  logic [DATA_BITS-1:0] storeData,
  output logic                 stall,
  output logic [DATA_BITS-1:0] loadData,
  output logic                 loadValid,
  output logic                 addrErr,
  output logic [ADDR_BITS-1:0] address,
  output logic [DATA_BITS-1:0] writeData,
  output logic                 memWrite,
  output logic                 memRead,
  input  logic [DATA_BITS-1:0] readDataMem
);

  lsu_state_e           state_q, state_d;
  logic [ADDR_BITS-1:0] word_q, word_d;
  logic [1:0]           off_q, off_d;
  logic [1:0]           size_q, size_d;
  logic                 unsigned_q, unsigned_d;
  logic [15:0]          sdata_q, sdata_d;
  logic [31:0]          load_data_q, load_data_d;
  logic                 load_valid_q, load_valid_d;
  logic                 addr_err_q, addr_err_d;

  logic [ADDR_BITS-1:0] req_word;
  logic [31:0]          align_load;
  logic [31:0]          align_store;

  assign req_word  = {2'b00, byteAddr[ADDR_BITS-1:2]};
  assign loadData  = load_data_q;
  assign loadValid = load_valid_q;
  assign addrErr   = addr_err_q;

  subword_align #(
    .BIG_ENDIAN(BIG_ENDIAN)
  ) u_align (
    .word_in    (readDataMem),
    .new_data   (sdata_q),
    .offset     (off_q),
    .size       (size_q),
    .is_unsigned(unsigned_q),
    .load_result(align_load),
    .store_word (align_store)
  );

  always_comb begin
    state_d      = state_q;
    word_d       = word_q;
    off_d        = off_q;
    size_d       = size_q;
    unsigned_d   = unsigned_q;
    sdata_d      = sdata_q;
    load_data_d  = load_data_q;
    load_valid_d = 1'b0;
    addr_err_d   = 1'b0;
    stall        = 1'b0;
    memRead      = 1'b1;
    memWrite     = 1'b0;
    address      = req_word;
    writeData    = storeData;

    case (state_q)
      IDLE: begin
        if (req && op_is_valid(memOp)) begin
          word_d     = req_word;
          off_d      = byteAddr[1:0];
          size_d     = memOp[1:0];
          unsigned_d = memOp[2];
          sdata_d    = storeData[15:0];
          if (is_misaligned(memOp[1:0], byteAddr[1:0])) begin
            addr_err_d = 1'b1;
          end else if (!memOp[3]) begin
            memRead = 1'b0;
            stall   = 1'b1;
            state_d = LD_EXT;
          end else if (memOp[1:0] == SIZE_WORD) begin
            memRead  = 1'b0;
            memWrite = 1'b1;
          end else begin
            memRead = 1'b0;
            stall   = 1'b1;
            state_d = ST_MERGE;
          end
        end
      end
      LD_EXT: begin
        address      = word_q;
        load_data_d  = align_load;
        load_valid_d = 1'b1;
        state_d      = IDLE;
      end
      ST_MERGE: begin
        address   = word_q;
        writeData = align_store;
        memRead   = 1'b0;
        memWrite  = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Reset must suppress the merge write issued in the same cycle, not just the next state.
    if (reset) begin
      stall    = 1'b0;
      memRead  = 1'b1;
      memWrite = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      word_q       <= '0;
      off_q        <= 2'b00;
      size_q       <= SIZE_BYTE;
      unsigned_q   <= 1'b0;
      sdata_q      <= 16'h0000;
      load_data_q  <= 32'h0000_0000;
      load_valid_q <= 1'b0;
      addr_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_q       <= word_d;
      off_q        <= off_d;
      size_q       <= size_d;
      unsigned_q   <= unsigned_d;
      sdata_q      <= sdata_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
      addr_err_q   <= addr_err_d;
    end
  end

endmodule
